// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: pushes PC/status, then fetches the vector.
// Optional macro BRK_SUPPORT_EN lets brk start a sequence at the lowest priority.
module interrupt_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic       reset_req,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       iflag,
    input  logic       brk,
    output logic       busy,
    output logic       setreset,
    output logic       setirq,
    output logic       setnmi,
    output logic       setstk,
    output logic       push_pch,
    output logic       push_pcl,
    output logic       push_p,
    output logic       vec_lo_ld,
    output logic       vec_hi_ld,
    output logic       set_iflag,
    output logic [7:0] vec_lo
);

    typedef enum logic [2:0] {IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H} state_t;
    typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;

    state_t state, state_next;
    kind_t  kind, kind_next;
    logic   nmi_q, nmi_pend, rst_pend;
    logic   rst_active, nmi_edge, irq_go, brk_go;
    logic   clear_nmi, clear_rst;

`ifdef BRK_SUPPORT_EN
    assign brk_go = brk;
`else
    logic unused_brk;
    assign unused_brk = brk;
    assign brk_go     = 1'b0;
`endif

    // A live reset_req counts immediately so a request aborts on the very next cycle.
    assign rst_active = rst_pend | reset_req;
    assign nmi_edge   = nmi_q & ~nmi_n;
    assign irq_go     = ~irq_n & ~iflag;

    always_comb begin
        state_next = state;
        kind_next  = kind;
        if (rst_active) begin
            state_next = VEC_L;
            kind_next  = K_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        if (nmi_pend) begin
                            state_next = PUSH_H;
                            kind_next  = K_NMI;
                        end else if (irq_go) begin
                            state_next = PUSH_H;
                            kind_next  = K_IRQ;
                        end else if (brk_go) begin
                            state_next = PUSH_H;
                            kind_next  = K_BRK;
                        end
                    end
                end
                PUSH_H:  state_next = PUSH_L;
                PUSH_L:  state_next = PUSH_P;
                PUSH_P:  state_next = VEC_L;
                VEC_L:   state_next = VEC_H;
                VEC_H:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign clear_nmi = (state_next == VEC_L) && (kind_next == K_NMI);
    assign clear_rst = (state_next == VEC_L) && (kind_next == K_RESET);

    function automatic logic [7:0] vec_base(input kind_t k);
        case (k)
            K_NMI:   return 8'hFA;
            K_RESET: return 8'hFC;
            default: return 8'hFE;
        endcase
    endfunction

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind      <= K_RESET;
            nmi_q     <= 1'b1;
            nmi_pend  <= 1'b0;
            rst_pend  <= 1'b1;
            busy      <= 1'b0;
            setreset  <= 1'b0;
            setirq    <= 1'b0;
            setnmi    <= 1'b0;
            setstk    <= 1'b0;
            push_pch  <= 1'b0;
            push_pcl  <= 1'b0;
            push_p    <= 1'b0;
            vec_lo_ld <= 1'b0;
            vec_hi_ld <= 1'b0;
            set_iflag <= 1'b0;
            vec_lo    <= 8'h00;
        end else begin
            state    <= state_next;
            kind     <= kind_next;
            nmi_q    <= nmi_n;
            // A fresh edge wins over the clear so it is serviced on a later sync.
            nmi_pend <= nmi_edge | (nmi_pend & ~clear_nmi);
            rst_pend <= clear_rst ? 1'b0 : (rst_pend | reset_req);

            busy      <= (state_next != IDLE);
            setreset  <= 1'b0;
            setirq    <= 1'b0;
            setnmi    <= 1'b0;
            setstk    <= 1'b0;
            push_pch  <= 1'b0;
            push_pcl  <= 1'b0;
            push_p    <= 1'b0;
            vec_lo_ld <= 1'b0;
            vec_hi_ld <= 1'b0;
            set_iflag <= 1'b0;
            vec_lo    <= 8'h00;
            case (state_next)
                PUSH_H: begin
                    setstk   <= 1'b1;
                    push_pch <= 1'b1;
                end
                PUSH_L: begin
                    setstk   <= 1'b1;
                    push_pcl <= 1'b1;
                end
                PUSH_P: begin
                    setstk <= 1'b1;
                    push_p <= 1'b1;
                end
                VEC_L: begin
                    vec_lo_ld <= 1'b1;
                    vec_lo    <= vec_base(kind_next);
                    setreset  <= (kind_next == K_RESET);
                    setnmi    <= (kind_next == K_NMI);
                    setirq    <= (kind_next == K_IRQ) || (kind_next == K_BRK);
                end
                VEC_H: begin
                    vec_hi_ld <= 1'b1;
                    set_iflag <= 1'b1;
                    vec_lo    <= vec_base(kind_next) | 8'h01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed scenarios queue expected
// per-cycle strobe vectors; a negedge monitor compares every cycle.
module tb_interrupt_sequencer;

    logic clk = 1'b0;
    logic rst_n, sync, reset_req, nmi_n, irq_n, iflag, brk;
    logic busy, setreset, setirq, setnmi, setstk, push_pch, push_pcl, push_p;
    logic vec_lo_ld, vec_hi_ld, set_iflag;
    logic [7:0] vec_lo;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .reset_req(reset_req),
        .nmi_n(nmi_n), .irq_n(irq_n), .iflag(iflag), .brk(brk),
        .busy(busy), .setreset(setreset), .setirq(setirq), .setnmi(setnmi),
        .setstk(setstk), .push_pch(push_pch), .push_pcl(push_pcl), .push_p(push_p),
        .vec_lo_ld(vec_lo_ld), .vec_hi_ld(vec_hi_ld), .set_iflag(set_iflag),
        .vec_lo(vec_lo)
    );

    // Bit order: busy setreset setirq setnmi setstk push_pch push_pcl push_p vec_lo_ld vec_hi_ld set_iflag | vec_lo
    logic [18:0] obs;
    assign obs = {busy, setreset, setirq, setnmi, setstk, push_pch, push_pcl, push_p,
                  vec_lo_ld, vec_hi_ld, set_iflag, vec_lo};

    localparam logic [18:0] E_PH     = {11'b1_000_1_100_000, 8'h00};
    localparam logic [18:0] E_PL     = {11'b1_000_1_010_000, 8'h00};
    localparam logic [18:0] E_PP     = {11'b1_000_1_001_000, 8'h00};
    localparam logic [18:0] E_VL_RST = {11'b1_100_0_000_100, 8'hFC};
    localparam logic [18:0] E_VH_RST = {11'b1_000_0_000_011, 8'hFD};
    localparam logic [18:0] E_VL_NMI = {11'b1_001_0_000_100, 8'hFA};
    localparam logic [18:0] E_VH_NMI = {11'b1_000_0_000_011, 8'hFB};
    localparam logic [18:0] E_VL_IRQ = {11'b1_010_0_000_100, 8'hFE};
    localparam logic [18:0] E_VH_IRQ = {11'b1_000_0_000_011, 8'hFF};

    typedef struct {
        string       name;
        logic [18:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   drain_req = 0;
    int   drain_seen = 0;
    string cur_test = "reset";

    task automatic expect_cycle(input string name, input logic [18:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic expect_irq_seq(input string tag);
        expect_cycle({tag, ".push_h"}, E_PH);
        expect_cycle({tag, ".push_l"}, E_PL);
        expect_cycle({tag, ".push_p"}, E_PP);
        expect_cycle({tag, ".vec_l"}, E_VL_IRQ);
        expect_cycle({tag, ".vec_h"}, E_VH_IRQ);
    endtask

    task automatic expect_nmi_seq(input string tag);
        expect_cycle({tag, ".push_h"}, E_PH);
        expect_cycle({tag, ".push_l"}, E_PL);
        expect_cycle({tag, ".push_p"}, E_PP);
        expect_cycle({tag, ".vec_l"}, E_VL_NMI);
        expect_cycle({tag, ".vec_h"}, E_VH_NMI);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        cur_test  = name;
        drain_req = drain_req + 1;
        cyc(2);
    endtask

    // Monitor: a busy cycle consumes one expected entry; an idle cycle must be all zero.
    always @(negedge clk) begin
        checks = checks + 1;
        if (busy === 1'b1) begin
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_busy (%s): got %h, required no activity", cur_test, obs);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (obs !== e.val) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %h, required %h", e.name, obs, e.val);
                end
            end
        end else if (obs !== 19'h0) begin
            errors = errors + 1;
            $display("FAIL idle_outputs (%s): got %h, required 00000", cur_test, obs);
        end
        if (drain_req != drain_seen) begin
            drain_seen = drain_req;
            checks = checks + 1;
            if (q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain_%s: got %0d pending, required 0 (next %s)",
                         cur_test, q.size(), q[0].name);
                q.delete();
            end
        end
    end

    initial begin
        sync = 0; reset_req = 0; nmi_n = 1; irq_n = 1; iflag = 1; brk = 0;
        rst_n = 1;
        #1 rst_n = 0;
        cyc(3);

        // Power-up reset sequence without sync
        cur_test = "reset";
        expect_cycle("reset.vec_l", E_VL_RST);
        expect_cycle("reset.vec_h", E_VH_RST);
        rst_n = 1;
        cyc(6);
        drain("reset");

        // Unmasked IRQ
        cur_test = "irq";
        iflag = 0; irq_n = 0; sync = 1;
        expect_irq_seq("irq");
        cyc(1);
        sync = 0; irq_n = 1;
        cyc(7);
        drain("irq");

        // Masked IRQ stays idle
        cur_test = "irq_masked";
        iflag = 1; irq_n = 0; sync = 1;
        cyc(1);
        sync = 0;
        cyc(4);
        irq_n = 1;
        drain("irq_masked");

        // NMI edge during IRQ sequence is held until the next sync
        cur_test = "nmi_during_irq";
        iflag = 0; irq_n = 0; sync = 1;
        expect_irq_seq("irq_then");
        cyc(1);
        sync = 0; irq_n = 1;
        cyc(1);
        nmi_n = 0;
        cyc(6);
        nmi_n = 1;
        expect_nmi_seq("nmi_after");
        sync = 1;
        cyc(1);
        sync = 0;
        cyc(7);
        drain("nmi_during_irq");

        // NMI beats IRQ at the same sync
        cur_test = "nmi_vs_irq";
        nmi_n = 0;
        cyc(3);
        irq_n = 0; iflag = 0; sync = 1;
        expect_nmi_seq("nmi_first");
        cyc(1);
        sync = 0; irq_n = 1;
        cyc(7);
        nmi_n = 1;
        drain("nmi_vs_irq");

        // Soft reset during PUSH_L aborts without push_p
        cur_test = "reset_req";
        iflag = 0; irq_n = 0; sync = 1;
        expect_cycle("abort.push_h", E_PH);
        expect_cycle("abort.push_l", E_PL);
        expect_cycle("abort.vec_l", E_VL_RST);
        expect_cycle("abort.vec_h", E_VH_RST);
        cyc(1);
        sync = 0; irq_n = 1;
        cyc(1);
        reset_req = 1;
        cyc(1);
        reset_req = 0;
        cyc(5);
        drain("reset_req");

        // Software break
        cur_test = "brk";
        iflag = 1; irq_n = 1; brk = 1; sync = 1;
`ifdef BRK_SUPPORT_EN
        expect_irq_seq("brk");
`endif
        cyc(1);
        sync = 0; brk = 0;
        cyc(7);
        drain("brk");

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: sync  input  1  high for one cycle at each instruction boundary.
REQ-004 SHALL have port: reset_req  input  1  level-high soft reset request.
REQ-005 SHALL have port: nmi_n  input  1  non-maskable interrupt, falling-edge sensitive.
REQ-006 SHALL have port: irq_n  input  1  maskable interrupt, level-low.
REQ-007 SHALL have port: iflag  input  1  processor interrupt-disable flag.
REQ-008 SHALL have port: brk  input  1  software break request at sync (only used with BRK_SUPPORT_EN).
REQ-009 SHALL have ports: busy, setreset, setirq, setnmi, setstk, push_pch, push_pcl, push_p, vec_lo_ld, vec_hi_ld, set_iflag  output  1 each  sequencing strobes to the PC-high/PC-low/stack/status datapath.
REQ-010 SHALL have port: vec_lo  output  8  low byte of vector address being fetched.

Function
REQ-011 SHALL implement states IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H; one cycle per non-IDLE state.
REQ-012 SHALL register nmi_n each cycle; 1->0 transition sets nmi_pend; nmi_pend clears on entry to VEC_L of an NMI sequence.
REQ-013 SHALL set rst_pend while reset_req=1; rst_pend clears on entry to VEC_L of a reset sequence.
REQ-014 SHALL, with rst_pend=1 in any state, enter VEC_L on the next cycle with kind=RESET, aborting any sequence in progress; no pushes.
REQ-015 SHALL, in IDLE with sync=1, select by priority nmi_pend > (irq_n=0 and iflag=0) > brk, latch kind, and enter PUSH_H next cycle; with none, stay IDLE.
REQ-016 SHALL NOT latch IRQ; irq_n is sampled only at sync in IDLE.
REQ-017 SHALL sequence PUSH_H -> PUSH_L -> PUSH_P -> VEC_L -> VEC_H -> IDLE.
REQ-018 SHALL assert setstk in all PUSH states; push_pch in PUSH_H, push_pcl in PUSH_L, push_p in PUSH_P.
REQ-019 SHALL, in VEC_L, assert vec_lo_ld and exactly one of setreset/setnmi/setirq per kind (setirq for IRQ and BRK).
REQ-020 SHALL drive vec_lo = 8'hFA (NMI), 8'hFC (RESET), 8'hFE (IRQ/BRK) in VEC_L, 8'hFB/8'hFD/8'hFF respectively in VEC_H, 8'h00 otherwise.
REQ-021 SHALL, in VEC_H, assert vec_hi_ld and set_iflag.
REQ-022 SHALL assert busy in every non-IDLE state; all other strobes 0 outside their states.
REQ-023 SHALL keep an NMI edge arriving during a sequence pending and service it at the next sync in IDLE.

Reset
REQ-024 SHALL, on rst_n=0, force state=IDLE, all outputs 0, vec_lo=8'h00, nmi_pend=0, nmi_n sample register=1, rst_pend=1.
REQ-025 SHALL, after rst_n deasserts, run the reset sequence (VEC_L, VEC_H) without waiting for sync.

Configuration
REQ-026 SHALL honour macro BRK_SUPPORT_EN: defined -> brk participates at lowest priority per REQ-015; undefined -> brk port present but ignored, BRK never starts a sequence.

Verification
REQ-027 SHALL cover: rst_n 0->1 -> cycle 1 VEC_L setreset=1 vec_lo=FC, cycle 2 VEC_H vec_lo=FD set_iflag=1, then busy=0.
REQ-028 SHALL cover: irq_n=0, iflag=0, sync pulse -> PUSH_H/L/P strobes with setstk=1, then VEC_L setirq=1 vec_lo=FE, VEC_H vec_lo=FF; iflag=1 -> stays IDLE.
REQ-029 SHALL cover: nmi_n falls during IRQ sequence -> IRQ completes with vec FE/FF, next sync starts NMI sequence with vec FA/FB.
REQ-030 SHALL cover: nmi_n and irq_n both active at same sync -> NMI serviced first (setnmi=1, vec_lo=FA).
REQ-031 SHALL cover: reset_req=1 during PUSH_L -> next cycle VEC_L with setreset=1, vec_lo=FC, no push_p.
REQ-032 SHALL cover: brk=1 at sync with BRK_SUPPORT_EN defined -> vec FE/FF sequence; undefined -> remains IDLE.
